cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
- Fetch/decode/execute sequencer for the 8-bit accumulator CPU model.
- Drives the instruction-register load strobe and reads back that register's one-hot decoded opcode lines (LD, ADD, SUB, AND, OR, STO, HALT).
- Sequences memory reads/writes through a req/ack handshake and issues PC, MAR, accumulator and ALU controls.
- Instruction format is two bytes: opcode byte (bits [2:0]), then operand-address byte.

Parameters:
- TIMEOUT, 16: max cycles to wait for mem_ack per request; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  level; leaves IDLE when sampled 1.
- op_ld, op_add, op_sub, op_and, op_or, op_sto, op_halt  in  1 each  decoded one-hot opcode lines from the instruction register.
- mem_ack  in  1  memory completion, single-cycle pulse.
- ir_strobe_n  out  1  instruction-register load strobe, active-low; the register captures on its falling edge.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (store accumulator), 0 = read.
- addr_sel  out  1  address mux select: 0 = PC, 1 = MAR.
- pc_inc  out  1  one-cycle PC increment pulse.
- mar_load  out  1  one-cycle pulse; MAR captures the data bus.
- acc_load  out  1  one-cycle pulse; accumulator captures the ALU result.
- alu_op  out  3  ALU function: 000 pass (LD), 001 ADD, 010 SUB, 011 AND, 100 OR.
- busy  out  1  1 in any state except IDLE, HALT and FAULT.
- halted  out  1  1 in HALT.
- fault  out  1  1 in FAULT.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- All registers update on rising clk. rst_n=0 at an edge forces: state IDLE, ir_strobe_n=1, all other outputs 0, instr_count=0, timeout counter 0. This applies in every state; a pending mem_req drops at that edge.
- Outputs are registered and depend on state only, except the ack-qualified pulses noted below.
- IDLE: all outputs idle. start=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ack: pc_inc=1 in that cycle -> IRLD.
- IRLD: ir_strobe_n=0 for exactly one cycle -> DECODE.
- DECODE: one settle cycle, then sample the opcode lines.
  - op_halt alone -> HALT.
  - Exactly one other line -> ADDR.
  - Zero lines or more than one line -> FAULT.
  - The decoded op is latched internally here and used in EXEC.
- ADDR: mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ack: mar_load=1 and pc_inc=1 in that cycle -> EXEC.
- EXEC: mem_req=1, addr_sel=1.
  - STO: mem_we=1.
  - Other ops: mem_we=0; alu_op is set from the latched op.
  - On mem_ack: acc_load=1 (not for STO), instr_count+1 (wraps at 2^CNT_W-1 -> 0) -> FETCH.
- HALT: halted=1; start is ignored; leaves only via reset. HALT is not counted as retired.
- FAULT: fault=1; leaves only via reset.
- Handshake rules:
  - mem_req stays 1 until the cycle mem_ack is sampled, then deasserts at the next edge.
  - mem_ack sampled while mem_req=0 is ignored.
  - An ack in the same cycle the request is first raised is valid.
  - Back-to-back requests across states carry no idle cycle.
- Timeout:
  - The counter clears on entry to FETCH, ADDR or EXEC and increments each cycle without ack.
  - TIMEOUT!=0 and count reaches TIMEOUT-1 with no ack -> FAULT at the next edge; mem_req drops.
  - An ack in that same final cycle wins over the timeout.
- alu_op holds its last value outside EXEC; it is 000 after reset.

Decomposition:
- Package cpu_pkg holds:
  - State enum: IDLE, FETCH, IRLD, DECODE, ADDR, EXEC, HALT, FAULT (3 bits).
  - ALU_OP constants (PASS/ADD/SUB/AND/OR).
  - Opcode constants 000..110, matching the instruction-register decode.
- One sub-module, mem_hs_timer: the req/ack timeout counter, with start, ack and expired ports.
- The FSM and output registers stay in cpu_ctrl_seq.

Test Plan:
- Reset then start=1; memory acks every request after 1 wait cycle; program ADD (001), addr 0x20 -> sequence FETCH, IRLD, DECODE, ADDR, EXEC; pc_inc pulses twice; acc_load once with alu_op=001; instr_count=1.
- STO (101) with zero-wait acks -> EXEC asserts mem_we=1 with addr_sel=1; no acc_load; next state FETCH.
- HALT (110) -> halted=1 and busy=0 after DECODE; further start and ack pulses have no effect; rst_n=0 for 1 cycle -> IDLE with all outputs at reset values.
- Decode lines all 0, and separately op_add=op_or=1 -> fault=1 after DECODE; no memory request issued.
- TIMEOUT=4 and mem_ack withheld in ADDR -> FAULT exactly 4 cycles after ADDR entry.
- Second run: ack on the 4th cycle -> no fault, EXEC entered.
- CNT_W=2: execute 5 LD instructions -> instr_count goes 1,2,3,0,1.
- Additionally, asserting rst_n=0 mid-EXEC drops mem_req at that edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the accumulator CPU control sequencer.
// Opcode values match the bit position of each decoded line from the instruction register.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_IRLD   = 3'd2,
        S_DECODE = 3'd3,
        S_ADDR   = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    localparam logic [2:0] OP_LD   = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_STO  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    // Lines are ordered {halt, sto, or, and, sub, add, ld}; callers guarantee one-hot.
    function automatic logic [2:0] encode_op(input logic [6:0] lines);
        logic [2:0] op;
        op = OP_LD;
        for (int i = 0; i < 7; i++) begin
            if (lines[i]) op = 3'(i);
        end
        return op;
    endfunction

    function automatic logic [2:0] alu_for_op(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mem_hs_timer.sv
// Watchdog for one memory req/ack handshake: counts unacknowledged request cycles
// and flags the last allowed cycle so the sequencer can abandon the request.
module mem_hs_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active && !ack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // An ack in the final cycle suppresses expiry, so the request still completes.
    assign expired = (TIMEOUT != 0) && active && !ack && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute sequencer: walks each two-byte instruction through memory
// handshakes and issues PC, MAR, IR, accumulator and ALU controls.
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_ld,
    input  logic             op_add,
    input  logic             op_sub,
    input  logic             op_and,
    input  logic             op_or,
    input  logic             op_sto,
    input  logic             op_halt,
    input  logic             mem_ack,
    output logic             ir_strobe_n,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             pc_inc,
    output logic             mar_load,
    output logic             acc_load,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             addr_sel_q, addr_sel_d;
    logic             ir_strobe_n_q, ir_strobe_n_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
    logic [6:0]       ops;
    logic             ack_v;
    logic             tmr_start;
    logic             tmr_expired;

    assign ops   = {op_halt, op_sto, op_or, op_and, op_sub, op_add, op_ld};
    assign ack_v = mem_req_q && mem_ack;

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        alu_op_d = alu_op_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (ack_v)            state_d = S_IRLD;
                else if (tmr_expired) state_d = S_FAULT;
            end
            S_IRLD:   state_d = S_DECODE;
            S_DECODE: begin
                if (ops == 7'b100_0000) begin
                    state_d = S_HALT;
                end else if ($countones(ops) == 1) begin
                    state_d = S_ADDR;
                    op_d    = encode_op(ops);
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_ADDR: begin
                if (ack_v)            state_d = S_EXEC;
                else if (tmr_expired) state_d = S_FAULT;
            end
            S_EXEC: begin
                if (ack_v) begin
                    state_d = S_FETCH;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (tmr_expired) begin
                    state_d = S_FAULT;
                end
            end
            default: state_d = state_q;
        endcase

        // Registered outputs follow the state being entered.
        mem_req_d     = (state_d == S_FETCH) || (state_d == S_ADDR) || (state_d == S_EXEC);
        addr_sel_d    = (state_d == S_EXEC);
        mem_we_d      = (state_d == S_EXEC) && (op_d == OP_STO);
        ir_strobe_n_d = (state_d != S_IRLD);
        busy_d        = (state_d != S_IDLE) && (state_d != S_HALT) && (state_d != S_FAULT);
        halted_d      = (state_d == S_HALT);
        fault_d       = (state_d == S_FAULT);
        if ((state_d == S_EXEC) && (op_d != OP_STO)) alu_op_d = alu_for_op(op_d);
    end

    // A fresh request starts whenever req will be high next cycle and the current one is over.
    assign tmr_start = mem_req_d && (!mem_req_q || ack_v);

    mem_hs_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (tmr_start),
        .active (mem_req_q),
        .ack    (mem_ack),
        .expired(tmr_expired)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_LD;
            alu_op_q      <= ALU_PASS;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            addr_sel_q    <= 1'b0;
            ir_strobe_n_q <= 1'b1;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            alu_op_q      <= alu_op_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            addr_sel_q    <= addr_sel_d;
            ir_strobe_n_q <= ir_strobe_n_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    // Strobes tied to the completing handshake fire in the ack cycle itself.
    assign pc_inc   = ack_v && ((state_q == S_FETCH) || (state_q == S_ADDR));
    assign mar_load = ack_v && (state_q == S_ADDR);
    assign acc_load = ack_v && (state_q == S_EXEC) && (op_q != OP_STO);

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign addr_sel    = addr_sel_q;
    assign ir_strobe_n = ir_strobe_n_q;
    assign alu_op      = alu_op_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: a memory/IR model answers the sequencer and a
// monitor compares every completed handshake against expectations queued by the stimulus.
module tb_cpu_ctrl_seq;

    localparam int NEVER = 1000;
    localparam logic [14:0] RESET_OUTS = 15'h4000;

    typedef struct packed {
        logic       we;
        logic       sel;
        logic       pc;
        logic       mar;
        logic       acc;
        logic [2:0] alu;
        logic [1:0] cnt;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mem_ack_gen = 1'b0;
    logic       ack_force = 1'b0;
    logic [6:0] ir_lines = 7'd0;
    wire        mem_ack = mem_ack_gen | ack_force;

    logic       ir_strobe_n, mem_req, mem_we, addr_sel, pc_inc, mar_load, acc_load;
    logic [2:0] alu_op;
    logic       busy, halted, fault;
    logic [1:0] instr_count;

    txn_t       exp_q[$];
    int         waits[$];
    logic [6:0] prog[$];
    int         def_wait = 1;
    int         n_checks = 0;
    int         n_pass = 0;
    int         pc_seen = 0;
    int         acc_seen = 0;
    logic [2:0] exp_alu = 3'b000;
    logic [1:0] exp_ret = 2'd0;

    cpu_ctrl_seq #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_ld(ir_lines[0]), .op_add(ir_lines[1]), .op_sub(ir_lines[2]), .op_and(ir_lines[3]),
        .op_or(ir_lines[4]), .op_sto(ir_lines[5]), .op_halt(ir_lines[6]),
        .mem_ack(mem_ack), .ir_strobe_n(ir_strobe_n), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .pc_inc(pc_inc), .mar_load(mar_load), .acc_load(acc_load),
        .alu_op(alu_op), .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [14:0] outs();
        return {ir_strobe_n, mem_req, mem_we, addr_sel, pc_inc, mar_load, acc_load,
                alu_op, busy, halted, fault, instr_count};
    endfunction

    // Memory: each new request takes its wait count from the queue, else the default.
    initial begin
        int  wcnt;
        int  cur_wait;
        bit  in_req;
        wcnt = 0; cur_wait = 0; in_req = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_gen = 1'b0;
            if (!mem_req) begin
                in_req = 0;
            end else begin
                if (!in_req) begin
                    in_req = 1;
                    wcnt = 0;
                    if (waits.size() > 0) cur_wait = waits.pop_front();
                    else cur_wait = def_wait;
                end
                if (cur_wait != NEVER && wcnt == cur_wait) begin
                    mem_ack_gen = 1'b1;
                    in_req = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Instruction register loads the next program opcode while the strobe is low.
    always @(negedge clk) begin
        if (!ir_strobe_n) begin
            if (prog.size() > 0) ir_lines = prog.pop_front();
            else ir_lines = 7'd0;
        end
    end

    // Monitor: every completed handshake must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pc_inc) pc_seen++;
            if (acc_load) acc_seen++;
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", 32'(outs()), 32'(RESET_OUTS));
                end else begin
                    txn_t e;
                    txn_t a;
                    e = exp_q.pop_front();
                    a = '{we: mem_we, sel: addr_sel, pc: pc_inc, mar: mar_load, acc: acc_load,
                          alu: alu_op, cnt: instr_count};
                    check("txn", 32'(a), 32'(e));
                end
            end
        end
    end

    task automatic push_txn(input logic we, sel, pc, mar, acc);
        exp_q.push_back('{we: we, sel: sel, pc: pc, mar: mar, acc: acc, alu: exp_alu, cnt: exp_ret});
    endtask

    // Full instruction: fetch, operand-address read, then execute access.
    task automatic push_instr(input logic [2:0] op);
        push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_txn(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        if (op != 3'b101) exp_alu = op;
        push_txn(op == 3'b101, 1'b1, 1'b0, 1'b0, op != 3'b101);
        exp_ret = exp_ret + 2'd1;
    endtask

    function automatic logic [6:0] line(input int op);
        return 7'(1 << op);
    endfunction

    function automatic bit cond(input int which);
        case (which)
            0:       return halted === 1'b1;
            1:       return fault === 1'b1;
            2:       return ir_strobe_n === 1'b0;
            default: return (mem_req === 1'b1) && (addr_sel === 1'b1);
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = cond(which);
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; ack_force = 1'b0; def_wait = 1;
        exp_q.delete(); waits.delete(); prog.delete();
        exp_alu = 3'b000; exp_ret = 2'd0;
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'(RESET_OUTS));
        rst_n = 1'b1;
    endtask

    initial begin
        int pc0;
        int acc0;

        // ADD then HALT, one wait cycle per access
        do_reset();
        prog.push_back(line(1)); prog.push_back(line(6));
        push_instr(3'b001);
        push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pc0 = pc_seen; acc0 = acc_seen;
        start = 1'b1;
        wait_for(0, 60, "add_reaches_halt");
        check("add_halt_flags", {busy, halted, fault}, 3'b010);
        check("add_count", 32'(instr_count), 32'd1);
        check("add_pc_pulses", 32'(pc_seen - pc0), 32'd3);
        check("add_acc_pulses", 32'(acc_seen - acc0), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 ack_force = 1'b1; start = 1'b0;
            @(posedge clk); #1 ack_force = 1'b0; start = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("halt_sticky", {halted, busy, mem_req, fault}, 4'b1000);
        check("halt_queue_empty", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("halt_reset_outs", 32'(outs()), 32'(RESET_OUTS));
        rst_n = 1'b1;

        // STO with zero-wait acks
        do_reset();
        def_wait = 0;
        prog.push_back(line(5)); prog.push_back(line(6));
        push_instr(3'b101);
        push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        acc0 = acc_seen;
        start = 1'b1;
        wait_for(0, 60, "sto_reaches_halt");
        check("sto_no_acc_load", 32'(acc_seen - acc0), 32'd0);
        check("sto_count", 32'(instr_count), 32'd1);
        check("sto_queue_empty", 32'(exp_q.size()), 32'd0);

        // Illegal decodes: no lines, then two lines
        for (int k = 0; k < 2; k++) begin
            do_reset();
            prog.push_back(k == 0 ? 7'd0 : (line(1) | line(4)));
            push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            start = 1'b1;
            wait_for(1, 40, "bad_decode_faults");
            repeat (5) @(negedge clk);
            check("bad_decode_state", {fault, busy, halted, mem_req}, 4'b1000);
            check("bad_decode_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Operand-address read never acknowledged
        do_reset();
        waits.push_back(1); waits.push_back(NEVER);
        prog.push_back(line(0));
        push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        wait_for(2, 40, "to_irld_seen");
        repeat (5) @(negedge clk);
        check("to_last_wait_cycle", {fault, mem_req}, 2'b01);
        @(negedge clk);
        check("to_fault_entered", {fault, mem_req, busy}, 3'b100);

        // Ack arrives on the final allowed cycle
        do_reset();
        waits.push_back(1); waits.push_back(3);
        prog.push_back(line(0)); prog.push_back(line(6));
        push_instr(3'b000);
        push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        wait_for(2, 40, "late_irld_seen");
        repeat (5) @(negedge clk);
        check("late_ack_cycle", {fault, mem_req, mar_load}, 3'b011);
        @(negedge clk);
        check("late_exec_entered", {fault, addr_sel, mem_req}, 3'b011);
        wait_for(0, 60, "late_reaches_halt");
        check("late_count", 32'(instr_count), 32'd1);

        // Five LDs through a 2-bit retired counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            prog.push_back(line(0));
            push_instr(3'b000);
        end
        prog.push_back(line(6));
        push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        wait_for(0, 200, "ld5_reaches_halt");
        check("ld5_count_wrapped", 32'(instr_count), 32'd1);
        check("ld5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset while the execute access is outstanding
        do_reset();
        waits.push_back(0); waits.push_back(0); waits.push_back(NEVER);
        prog.push_back(line(1));
        push_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_txn(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        wait_for(3, 40, "mid_exec_seen");
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_exec_reset_outs", 32'(outs()), 32'(RESET_OUTS));
        check("mid_exec_queue_empty", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
